// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : conv_pkg
//  Description : Shared types and widths for the CONVEX point-input path.
//                PT_W  - coordinate width
//                NIB_W - width of one serialized PT_XY beat
//                pt_t  - one (X,Y) point
//                tx_state_t - PT_XY transmitter beat sequencer states
//  Revision    : 1.0  initial release
// ============================================================================
package conv_pkg;

    localparam int PT_W  = 10;
    localparam int NIB_W = 5;

    typedef struct packed {
        logic [PT_W-1:0] x;
        logic [PT_W-1:0] y;
    } pt_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B0   = 3'd1,
        B1   = 3'd2,
        B2   = 3'd3,
        B3   = 3'd4
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/pt_xy_tx_if.sv
`default_nettype none
// ============================================================================
//  Interface   : pt_xy_tx_if
//  Description : Upstream point handshake plus READ_PT/PT_XY consumer side.
//                master : driven by the producer/consumer environment
//                slave  : the pt_xy_tx transmitter
//  Signals     : in_v, in_x, in_y, in_rdy   - upstream point push
//                read_pt, pt_xy, tx_busy    - serial point transfer
//                underrun                   - sticky empty-request flag
//  Revision    : 1.0  initial release
// ============================================================================
interface pt_xy_tx_if;
    import conv_pkg::*;

    logic              in_v;
    logic [PT_W-1:0]   in_x;
    logic [PT_W-1:0]   in_y;
    logic              in_rdy;
    logic              read_pt;
    logic [NIB_W-1:0]  pt_xy;
    logic              tx_busy;
    logic              underrun;

    modport master (
        output in_v, in_x, in_y, read_pt,
        input  in_rdy, pt_xy, tx_busy, underrun
    );

    modport slave (
        input  in_v, in_x, in_y, read_pt,
        output in_rdy, pt_xy, tx_busy, underrun
    );

endinterface
`default_nettype wire

// File: rtl/pt_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pt_fifo
//  Description : Synchronous FIFO of pt_t points, DEPTH entries (power of 2).
//                No bypass: a point written at one edge is visible on dout
//                from the next edge. Push while full / pop while empty are
//                ignored.
//  Ports       : clk, rst_n (async, active-low)
//                push, din          - write side
//                pop,  dout         - read side (dout = head, show-ahead)
//                full, empty, count - occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module pt_fifo
    import conv_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire pt_t                        din,
    output      pt_t                        dout,
    output      logic                       full,
    output      logic                       empty,
    output      logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full_cnt = (AW+1)'(DEPTH);

    pt_t           mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == c_full_cnt);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop  && !empty;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers/count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pt_xy_tx.sv
`default_nettype none
// ============================================================================
//  Module      : pt_xy_tx
//  Description : CONVEX point-stream transmitter. Buffers (X,Y) points in a
//                pt_fifo and, on READ_PT, serializes one point as four 5-bit
//                beats X[9:5], X[4:0], Y[9:5], Y[4:0] on PT_XY. Transfers run
//                back-to-back when READ_PT is high in the last beat.
//  Ports       : clk            - clock, rising edge
//                rst_n          - asynchronous reset, active-low
//                bus (slave)    - in_v/in_x/in_y/in_rdy, read_pt, pt_xy,
//                                 tx_busy, underrun
//  Parameters  : DEPTH          - FIFO depth in points (power of 2, 2..64)
//  Options     : PT_XY_UNDERRUN_EN - when defined, underrun is a sticky flag
//                set by READ_PT at a start opportunity with an empty FIFO;
//                otherwise underrun is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module pt_xy_tx
    import conv_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    pt_xy_tx_if.slave   bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] c_full_cnt = CW'(DEPTH);

    pt_t              fifo_din;
    pt_t              fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             push;
    logic             start;
    logic             start_slot;

    tx_state_t        state_q,   state_d;
    pt_t              hold_q,    hold_d;
    logic [NIB_W-1:0] pt_xy_q,   pt_xy_d;
    logic             tx_busy_q, tx_busy_d;

    assign fifo_din.x  = bus.in_x;
    assign fifo_din.y  = bus.in_y;
    assign bus.in_rdy  = (fifo_count != c_full_cnt);
    assign push        = bus.in_v && !fifo_full;

    pt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (start),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A new transfer may only begin from IDLE or in the final beat.
    assign start_slot = (state_q == IDLE) || (state_q == B3);
    assign start      = start_slot && bus.read_pt && !fifo_empty;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE,
            B3: begin
                if (start) begin
                    state_d = B0;
                    hold_d  = fifo_dout;
                end else begin
                    state_d = IDLE;
                end
            end
            B0:      state_d = B1;
            B1:      state_d = B2;
            B2:      state_d = B3;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered
        // and line up with the state they describe.
        unique case (state_d)
            B0:      pt_xy_d = hold_d.x[PT_W-1 -: NIB_W];
            B1:      pt_xy_d = hold_d.x[NIB_W-1:0];
            B2:      pt_xy_d = hold_d.y[PT_W-1 -: NIB_W];
            B3:      pt_xy_d = hold_d.y[NIB_W-1:0];
            default: pt_xy_d = '0;
        endcase
        tx_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            pt_xy_q   <= '0;
            tx_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            pt_xy_q   <= pt_xy_d;
            tx_busy_q <= tx_busy_d;
        end
    end

    assign bus.pt_xy   = pt_xy_q;
    assign bus.tx_busy = tx_busy_q;

`ifdef PT_XY_UNDERRUN_EN
    logic underrun_q, underrun_d;

    always_comb begin
        underrun_d = underrun_q | (start_slot && bus.read_pt && fifo_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign bus.underrun = underrun_q;
`else
    assign bus.underrun = 1'b0;
`endif

endmodule
`default_nettype wire
